prio_arbiter_rr: RTL and testbench

- Parametrised, registered N-input priority encoder/arbiter with a valid/ready grant handshake.
- Two modes:
  - Fixed priority: highest index wins, as in the combinational 4-to-2 encoder.
  - Round-robin: rotating priority.
- Sits between N requesters and a shared resource. The grant index and one-hot grant are held stable until the consumer accepts them.

---
 rtl/prio_arbiter_rr.sv | 124 ++++++++++++
 tb/tb_prio_arbiter_rr.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_rr.sv
// Registered N-input arbiter with fixed-priority or round-robin selection.
// The grant is held stable until the consumer accepts it with gnt_ready.
module prio_arbiter_rr #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          mode,
    output logic          gnt_valid,
    input  logic          gnt_ready,
    output logic [IW-1:0] gnt_idx,
    output logic [N-1:0]  gnt_onehot,
    output logic          req_none
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [N-1:0]  onehot_reg, onehot_next;
    logic [IW-1:0] ptr_reg, ptr_next;

    logic          handshake;
    logic [IW-1:0] ptr_eff;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_onehot;

    assign handshake = (state_reg == GRANT) && gnt_ready;

    // On a handshake the new arbitration already uses the advanced pointer.
    always_comb begin
        ptr_eff = ptr_reg;
        if (handshake) begin
            if (idx_reg == '0) begin
                ptr_eff = IW'(N - 1);
            end else begin
                ptr_eff = idx_reg - 1'b1;
            end
        end
    end

    // Scan descending from the start point; fixed priority always starts at N-1.
    always_comb begin
        int unsigned t;
        int unsigned sel;
        logic        found;
        win_idx = '0;
        found   = 1'b0;
        t       = 0;
        sel     = 0;
        for (int k = 0; k < N; k++) begin
            t = int'(ptr_eff) + N - k;
            if (t >= N) begin
                t = t - N;
            end
            sel = mode ? t : (N - 1 - k);
            if (!found && req[IW'(sel)]) begin
                found   = 1'b1;
                win_idx = IW'(sel);
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_win_onehot
        assign win_onehot[gi] = (win_idx == IW'(gi));
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        onehot_next = onehot_reg;
        ptr_next    = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    idx_next    = win_idx;
                    onehot_next = win_onehot;
                    state_next  = GRANT;
                end
            end
            GRANT: begin
                if (gnt_ready) begin
                    ptr_next = ptr_eff;
                    if (|req) begin
                        idx_next    = win_idx;
                        onehot_next = win_onehot;
                    end else begin
                        onehot_next = '0;
                        state_next  = IDLE;
                    end
                end
            end
            default: begin
                onehot_next = '0;
                state_next  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            onehot_reg <= '0;
            ptr_reg    <= IW'(N - 1);
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            onehot_reg <= onehot_next;
            ptr_reg    <= ptr_next;
        end
    end

    assign gnt_valid  = (state_reg == GRANT);
    assign gnt_idx    = idx_reg;
    assign gnt_onehot = onehot_reg;
    assign req_none   = ~|req;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Self-checking bench for prio_arbiter_rr: directed scenarios followed by random
// traffic, all compared against a behavioural grant model.
module tb_prio_arbiter_rr;

    localparam int N  = 8;
    localparam int IW = $clog2(N);

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic          mode;
    logic          gnt_valid;
    logic          gnt_ready;
    logic [IW-1:0] gnt_idx;
    logic [N-1:0]  gnt_onehot;
    logic          req_none;

    int checks;
    int failures;

    // Behavioural model state
    bit m_valid;
    int m_idx;
    int m_ptr;

    prio_arbiter_rr #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mode       (mode),
        .gnt_valid  (gnt_valid),
        .gnt_ready  (gnt_ready),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .req_none   (req_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester order: fixed = N-1 down to 0; round-robin = p, p-1, ... wrapping.
    function automatic int pick(input logic [N-1:0] r, input logic m, input int p);
        int order [N];
        for (int k = 0; k < N; k++) begin
            order[k] = m ? ((p - k + N) % N) : (N - 1 - k);
        end
        for (int k = 0; k < N; k++) begin
            if (r[order[k]]) return order[k];
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, model update and output comparison.
    task automatic drive(input logic [N-1:0] r, input logic m, input logic rd, input logic rs);
        logic [N-1:0] exp_oh;
        req       = r;
        mode      = m;
        gnt_ready = rd;
        rst       = rs;
        #1;
        chk("req_none", req_none, (r == '0));
        @(posedge clk);
        if (rs) begin
            m_valid = 0;
            m_idx   = 0;
            m_ptr   = N - 1;
        end else if (!m_valid) begin
            if (r != '0) begin
                m_idx   = pick(r, m, m_ptr);
                m_valid = 1;
            end
        end else if (rd) begin
            m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
            if (r != '0) m_idx = pick(r, m, m_ptr);
            else m_valid = 0;
        end
        #1;
        exp_oh = m_valid ? (N'(1) << m_idx) : '0;
        chk("gnt_valid", gnt_valid, m_valid);
        chk("gnt_idx", gnt_idx, m_idx);
        chk("gnt_onehot", gnt_onehot, exp_oh);
        $display("t=%0t rst=%0b mode=%0b req=%02h rdy=%0b -> valid=%0b idx=%0d onehot=%02h",
                 $time, rs, m, r, rd, gnt_valid, gnt_idx, gnt_onehot);
    endtask

    initial begin
        int rr_seq [9];
        logic [N-1:0] r;
        checks    = 0;
        failures  = 0;
        m_valid   = 0;
        m_idx     = 0;
        m_ptr     = N - 1;
        rst       = 1'b1;
        req       = '0;
        mode      = 1'b0;
        gnt_ready = 1'b0;

        // Reset state
        drive('0, 0, 0, 1);
        drive('0, 0, 0, 1);
        chk("reset_valid", gnt_valid, 1'b0);
        chk("reset_idx", gnt_idx, 0);

        // Fixed priority sweep over the low four requesters
        for (int i = 0; i < 16; i++) drive(N'(i), 0, 1, 0);
        drive('0, 0, 1, 0);
        chk("sweep_idle", gnt_valid, 1'b0);

        // Round-robin with all requesting: 7,6,...,0,7 with no bubble
        rr_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        drive('0, 0, 0, 1);
        for (int i = 0; i < 9; i++) begin
            drive(8'hFF, 1, 1, 0);
            chk("rr_seq", gnt_idx, rr_seq[i]);
            chk("rr_valid", gnt_valid, 1'b1);
        end

        // Grant held while not ready, even as req changes
        drive('0, 0, 0, 1);
        drive(8'h81, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive((i >= 1) ? 8'h01 : 8'h81, 0, 0, 0);
            chk("hold_idx", gnt_idx, 7);
            chk("hold_onehot", gnt_onehot, 8'h80);
        end
        drive(8'h01, 0, 1, 0);
        chk("hold_release", gnt_idx, 0);

        // Round-robin wrap fairness after granting idx 0
        drive('0, 0, 0, 1);
        drive(8'h01, 1, 0, 0);
        drive(8'h05, 1, 1, 0);
        chk("wrap_a", gnt_idx, 2);
        drive(8'h05, 1, 1, 0);
        chk("wrap_b", gnt_idx, 0);
        drive(8'h05, 1, 1, 0);
        chk("wrap_c", gnt_idx, 2);

        // Reset in the middle of a grant, then pointer is back at N-1
        drive(8'h20, 0, 0, 1);
        drive(8'h20, 0, 0, 0);
        chk("pre_rst_idx", gnt_idx, 5);
        drive(8'h20, 0, 0, 1);
        chk("mid_rst_valid", gnt_valid, 1'b0);
        chk("mid_rst_onehot", gnt_onehot, 0);
        drive(8'hFF, 1, 0, 0);
        chk("post_rst_idx", gnt_idx, 7);

        // Single request, dropped after its handshake
        drive('0, 0, 0, 1);
        drive(8'h10, 0, 1, 0);
        chk("single_idx", gnt_idx, 4);
        drive('0, 0, 1, 0);
        chk("single_idle", gnt_valid, 1'b0);
        drive('0, 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r = N'($urandom) & N'($urandom);
            drive(r, 1'($urandom), ($urandom_range(3) != 0), ($urandom_range(40) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
